stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control FSM and time counters for the stopwatch.
- Consumes single-cycle tick enables from the clock-divider block: 1 Hz count tick, 2 Hz adjust tick, blink tick.
- Consumes debounced button pulses and switch levels.
- Sequences run/pause/adjust modes and owns the minutes/seconds registers that drive the display path.

Parameters:
- MAX_MIN, 59, terminal value of the minutes field (wraps to 0 after this).
- MAX_SEC, 59, terminal value of the seconds field (wraps to 0 after this).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- pause_btn  in  1  debounced single-cycle pulse; toggles the paused flag.
- adj  in  1  level; 1 = adjust mode.
- sel  in  1  level; in adjust mode, 0 = adjust seconds, 1 = adjust minutes.
- count_tick  in  1  single-cycle 1 Hz enable.
- adj_tick  in  1  single-cycle 2 Hz enable.
- blink_tick  in  1  single-cycle enable that toggles the blank phase.
- minutes  out  6  current minutes, binary, 0..MAX_MIN.
- seconds  out  6  current seconds, binary, 0..MAX_SEC.
- running  out  1  1 only in state RUN.
- blank_min  out  1  1 = display blanks the minutes digits.
- blank_sec  out  1  1 = display blanks the seconds digits.
- rollover  out  1  one-cycle pulse when MAX_MIN:MAX_SEC -> 00:00 in RUN.

Behaviour:
- All outputs are registered. Effects of a tick or pulse are visible the cycle after the input is sampled high.
- Reset (sync, rst=1 at posedge), all outputs:
  - minutes=0, seconds=0, paused flag=0, state=RUN.
  - running=1, blank_min=0, blank_sec=0, rollover=0.
  - Blink phase=0.
  - Reset overrides every other input in the same cycle.
  - Asserting reset mid-count or mid-adjust discards all state.
- State encoding: RUN, PAUSE, ADJ.
- Transition priority, highest first: rst > adj > paused flag.
  - adj=1 -> ADJ from any state.
  - adj=0 and paused=0 -> RUN.
  - adj=0 and paused=1 -> PAUSE.
- pause_btn toggles the paused flag in every state, including ADJ. The flag change affects the state starting the next cycle.
- RUN, on count_tick:
  - seconds<MAX_SEC: seconds+1.
  - seconds==MAX_SEC: seconds=0, minutes+1.
  - minutes==MAX_MIN and seconds==MAX_SEC: both go to 0 and rollover=1 for exactly one cycle.
- PAUSE:
  - count_tick and adj_tick ignored.
  - Counts hold.
- ADJ:
  - count_tick ignored.
  - On adj_tick, the field selected by sel increments by 1. MAX wraps to 0 with no carry into the other field.
  - A sel change takes effect on the next adj_tick.
  - blink_tick toggles the blink phase.
  - blank_sec = phase & ~sel.
  - blank_min = phase & sel.
- Outside ADJ: blink phase is forced to 0 and both blank outputs are 0.
- Simultaneous events:
  - count_tick with pause_btn in RUN: the tick is applied, then the state becomes PAUSE.
  - adj rising with count_tick in the same cycle: the tick is applied (state still RUN that cycle).
  - adj_tick and blink_tick together: both are applied.
- Ticks are assumed single-cycle. A tick held high for N cycles counts N times; the upstream divider guarantees pulses.

Optional Feature:
- Macro: STOPWATCH_CTRL_ADJ_CARRY_EN.
- Defined: in ADJ with sel=0, seconds wrapping MAX_SEC->0 also increments minutes, and minutes itself wraps MAX_MIN->0. rollover stays 0 in ADJ.
- Undefined: seconds wrap without carry, as described in Behaviour.
- Port list is identical in both builds.

Test Plan:
- Reset then 61 count_ticks -> minutes=1, seconds=1; running=1; rollover never asserted.
- Preload to 59:59 via ADJ (sel=1 x59 adj_ticks, sel=0 x59 adj_ticks), adj=0, one count_tick -> 00:00 with rollover high exactly 1 cycle.
- In RUN at 00:05, pause_btn coincident with count_tick -> 00:06 and running=0. 5 more count_ticks -> still 00:06. pause_btn -> running=1, next tick gives 00:07.
- adj=1, sel=0, at 00:59: adj_tick -> 00:00 with minutes unchanged. With STOPWATCH_CTRL_ADJ_CARRY_EN defined -> 01:00.
- adj=1, sel=1, 4 blink_ticks -> blank_min sequence 1,0,1,0 and blank_sec stays 0. adj=0 -> both blanks 0 next cycle.
- rst asserted for 1 cycle at 12:34 in ADJ with blank_min=1 -> next cycle 00:00, running=1, blank_min=0, blank_sec=0, rollover=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Control FSM and minutes/seconds counters for the stopwatch. It sequences
//   the run, pause and adjust modes from debounced buttons/switches and tick
//   enables that come from the clock divider. Every output is registered.
//
// Optional build feature (macro STOPWATCH_CTRL_ADJ_CARRY_EN):
//   When defined, the seconds field wrapping during seconds-adjust carries
//   into the minutes field. The minutes field then wraps on its own, and
//   rollover is never raised in adjust mode.
//   When undefined, each field wraps independently while adjusting.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   rst         in   synchronous active-high reset
//   pause_btn   in   single-cycle pulse, toggles the paused flag
//   adj         in   level, 1 = adjust mode
//   sel         in   level, adjust target (0 = seconds, 1 = minutes)
//   count_tick  in   1 Hz single-cycle enable (counting in RUN)
//   adj_tick    in   2 Hz single-cycle enable (increment in ADJ)
//   blink_tick  in   single-cycle enable that toggles the blank phase in ADJ
//   minutes     out  6-bit binary minutes, 0..MAX_MIN
//   seconds     out  6-bit binary seconds, 0..MAX_SEC
//   running     out  1 only while in RUN
//   blank_min   out  blank the minutes digits
//   blank_sec   out  blank the seconds digits
//   rollover    out  one-cycle pulse on MAX_MIN:MAX_SEC -> 00:00 in RUN
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int MAX_MIN = 59,
    parameter int MAX_SEC = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_btn,
    input  logic       adj,
    input  logic       sel,
    input  logic       count_tick,
    input  logic       adj_tick,
    input  logic       blink_tick,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       blank_min,
    output logic       blank_sec,
    output logic       rollover
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_ADJ   = 2'd2
    } state_e;

    localparam logic [5:0] MAX_MIN_V = 6'(MAX_MIN);
    localparam logic [5:0] MAX_SEC_V = 6'(MAX_SEC);

    // Wrapping increment for one field. The >= form also recovers a field
    // that holds an out-of-range value.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_v);
        logic [5:0] r;
        if (v >= max_v) begin
            r = 6'd0;
        end else begin
            r = v + 6'd1;
        end
        return r;
    endfunction

    state_e     state_q, state_d;
    logic       paused_q, paused_d;
    logic       phase_q, phase_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       running_q, running_d;
    logic       blank_min_q, blank_min_d;
    logic       blank_sec_q, blank_sec_d;
    logic       rollover_q, rollover_d;

    // Next-state, counter and output computation.
    always_comb begin
        state_d     = state_q;
        paused_d    = paused_q ^ pause_btn;
        phase_d     = 1'b0;
        min_d       = min_q;
        sec_d       = sec_q;
        rollover_d  = 1'b0;
        running_d   = 1'b0;
        blank_min_d = 1'b0;
        blank_sec_d = 1'b0;

        // The toggled paused flag steers the state entered at this edge.
        if (adj) begin
            state_d = ST_ADJ;
        end else if (paused_d) begin
            state_d = ST_PAUSE;
        end else begin
            state_d = ST_RUN;
        end

        // The current state decides what this cycle's ticks do.
        case (state_q)
            ST_RUN: begin
                if (count_tick) begin
                    if (sec_q >= MAX_SEC_V) begin
                        sec_d = 6'd0;
                        if (min_q >= MAX_MIN_V) begin
                            min_d      = 6'd0;
                            rollover_d = 1'b1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q;
                end
            end
            ST_PAUSE: begin
                min_d = min_q;
                sec_d = sec_q;
            end
            ST_ADJ: begin
                phase_d = phase_q ^ blink_tick;
                if (adj_tick) begin
                    if (sel) begin
                        min_d = wrap_inc(min_q, MAX_MIN_V);
                    end else begin
                        sec_d = wrap_inc(sec_q, MAX_SEC_V);
`ifdef STOPWATCH_CTRL_ADJ_CARRY_EN
                        if (sec_q >= MAX_SEC_V) begin
                            min_d = wrap_inc(min_q, MAX_MIN_V);
                        end else begin
                            min_d = min_q;
                        end
`else
                        min_d = min_q;
`endif
                    end
                end else begin
                    sec_d = sec_q;
                end
            end
            default: begin
                min_d = min_q;
                sec_d = sec_q;
            end
        endcase

        // The blink phase only survives while staying in ADJ.
        if (state_d != ST_ADJ) begin
            phase_d = 1'b0;
        end else begin
            phase_d = phase_d;
        end

        running_d   = (state_d == ST_RUN);
        blank_min_d = phase_d & sel;
        blank_sec_d = phase_d & ~sel;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            paused_q    <= 1'b0;
            phase_q     <= 1'b0;
            min_q       <= 6'd0;
            sec_q       <= 6'd0;
            running_q   <= 1'b1;
            blank_min_q <= 1'b0;
            blank_sec_q <= 1'b0;
            rollover_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            paused_q    <= paused_d;
            phase_q     <= phase_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            running_q   <= running_d;
            blank_min_q <= blank_min_d;
            blank_sec_q <= blank_sec_d;
            rollover_q  <= rollover_d;
        end
    end

    assign minutes   = min_q;
    assign seconds   = sec_q;
    assign running   = running_q;
    assign blank_min = blank_min_q;
    assign blank_sec = blank_sec_q;
    assign rollover  = rollover_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Self-checking bench for stopwatch_ctrl. A reference model tracks the time
//   as a single count of seconds (0..3599) and the mode as a small integer.
//   Every cycle, all outputs are compared with the model. Directed scenarios
//   follow the stopwatch use cases, and a randomized phase comes after them.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause_btn = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic       count_tick = 1'b0;
    logic       adj_tick = 1'b0;
    logic       blink_tick = 1'b0;
    logic [5:0] minutes, seconds;
    logic       running, blank_min, blank_sec, rollover;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0 = RUN, 1 = PAUSE, 2 = ADJ.
    int m_tot    = 0;
    int m_mode   = 0;
    bit m_paused = 1'b0;
    bit m_phase  = 1'b0;
    bit m_roll   = 1'b0;
    bit m_rsel   = 1'b0;

    stopwatch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pause_btn  (pause_btn),
        .adj        (adj),
        .sel        (sel),
        .count_tick (count_tick),
        .adj_tick   (adj_tick),
        .blink_tick (blink_tick),
        .minutes    (minutes),
        .seconds    (seconds),
        .running    (running),
        .blank_min  (blank_min),
        .blank_sec  (blank_sec),
        .rollover   (rollover)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_update();
        int  mm, ss, new_mode;
        if (rst) begin
            m_tot = 0; m_mode = 0; m_paused = 1'b0; m_phase = 1'b0; m_roll = 1'b0;
        end else begin
            m_roll = 1'b0;
            mm = m_tot / 60;
            ss = m_tot % 60;
            if (m_mode == 0 && count_tick) begin
                if (m_tot == 3599) m_roll = 1'b1;
                m_tot = (m_tot + 1) % 3600;
            end else if (m_mode == 2 && adj_tick) begin
                if (sel) begin
                    m_tot = ((mm + 1) % 60) * 60 + ss;
                end else begin
`ifdef STOPWATCH_CTRL_ADJ_CARRY_EN
                    m_tot = (m_tot + 1) % 3600;
`else
                    m_tot = mm * 60 + (ss + 1) % 60;
`endif
                end
            end
            m_paused = m_paused ^ pause_btn;
            new_mode = adj ? 2 : (m_paused ? 1 : 0);
            m_phase  = (m_mode == 2 && new_mode == 2) ? (m_phase ^ blink_tick) : 1'b0;
            m_mode   = new_mode;
        end
        m_rsel = sel;
    endtask

    task automatic check_all();
        chk_eq("minutes",   int'(minutes),   m_tot / 60);
        chk_eq("seconds",   int'(seconds),   m_tot % 60);
        chk_eq("running",   int'(running),   (m_mode == 0) ? 1 : 0);
        chk_eq("blank_min", int'(blank_min), int'(m_phase & m_rsel));
        chk_eq("blank_sec", int'(blank_sec), int'(m_phase & ~m_rsel));
        chk_eq("rollover",  int'(rollover),  int'(m_roll));
    endtask

    // One clock with the given pulses; level inputs come from module variables.
    task automatic step(input logic pb, input logic ct, input logic at, input logic bt);
        pause_btn = pb; count_tick = ct; adj_tick = at; blink_tick = bt;
        model_update();
        @(posedge clk);
        #1;
        check_all();
        pause_btn = 1'b0; count_tick = 1'b0; adj_tick = 1'b0; blink_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        int roll_seen;
        @(negedge clk);
        adj = 1'b0; sel = 1'b0;
        do_reset();
        chk_eq("reset_running", int'(running), 1);
        chk_eq("reset_time",    int'({minutes, seconds}), 0);

        // 61 count ticks -> 01:01, never a rollover.
        roll_seen = 0;
        for (int i = 0; i < 61; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (rollover) roll_seen++;
        end
        chk_eq("t61_min", int'(minutes), 1);
        chk_eq("t61_sec", int'(seconds), 1);
        chk_eq("t61_noroll", roll_seen, 0);

        // Preload 59:59 through ADJ, then one count tick rolls over.
        do_reset();
        adj = 1'b1; sel = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 59; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        sel = 1'b0;
        for (int i = 0; i < 59; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk_eq("preload", int'(minutes) * 60 + int'(seconds), 3599);
        adj = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_eq("roll_time", int'({minutes, seconds}), 0);
        chk_eq("roll_pulse", int'(rollover), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_eq("roll_once", int'(rollover), 0);

        // Pause coincident with a tick.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_eq("pause_sec", int'(seconds), 6);
        chk_eq("pause_run", int'(running), 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_eq("paused_hold", int'(seconds), 6);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_eq("resume_run", int'(running), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_eq("resume_sec", int'(seconds), 7);

        // Seconds-adjust wrap at 00:59.
        do_reset();
        adj = 1'b1; sel = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 59; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk_eq("adjwrap_sec", int'(seconds), 0);
`ifdef STOPWATCH_CTRL_ADJ_CARRY_EN
        chk_eq("adjwrap_min", int'(minutes), 1);
`else
        chk_eq("adjwrap_min", int'(minutes), 0);
`endif
        chk_eq("adjwrap_noroll", int'(rollover), 0);

        // Blink sequence on minutes.
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            chk_eq("blink_min", int'(blank_min), (i % 2 == 0) ? 1 : 0);
            chk_eq("blink_sec", int'(blank_sec), 0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        adj = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_eq("unblank", int'({blank_min, blank_sec}), 0);

        // Reset at 12:34 in ADJ with minutes blanked.
        do_reset();
        adj = 1'b1; sel = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        sel = 1'b0;
        for (int i = 0; i < 34; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        sel = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_eq("pre_rst_time", int'(minutes) * 60 + int'(seconds), 12 * 60 + 34);
        chk_eq("pre_rst_blank", int'(blank_min), 1);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        chk_eq("rst_time", int'({minutes, seconds}), 0);
        chk_eq("rst_flags", int'({running, blank_min, blank_sec, rollover}), 8);
        adj = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) adj = ~adj;
            if ($urandom_range(0, 9) == 0)  sel = ~sel;
            rst = ($urandom_range(0, 499) == 0);
            step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0));
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
